sar_adc_ctrl: RTL and testbench

Digital successive-approximation controller for the on-die analog macro. It drives the track/hold switch and the capacitive-DAC trial code onto the analog pins, and samples the macro's asynchronous comparator output through a synchronizer. It resolves one bit per trial, MSB first, and presents a registered conversion result with a one-cycle done strobe to the downstream digital readout.

---
 rtl/sar_adc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_ctrl
//  Description : Successive-approximation controller for the on-die analog
//                macro. Drives track/hold and the capacitive-DAC trial code,
//                resolves one bit per trial (MSB first) from a synchronized
//                comparator, and presents a registered result with a
//                one-cycle done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int c_CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(WIDTH);

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_MSB     = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE     = c_IDX_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   c_MIDSCALE    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [WIDTH-1:0]     r_trial;
    logic [WIDTH-1:0]     w_trial_next;
    logic [WIDTH-1:0]     r_result;
    logic                 w_result_load;
    logic                 r_cmp_meta;
    logic                 r_cmp_s;
    logic [WIDTH-1:0]     w_bit_mask;
    logic [WIDTH-1:0]     w_clr_mask;
    logic [WIDTH-1:0]     w_decided;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_meta <= 1'b0;
            r_cmp_s    <= 1'b0;
        end else begin
            r_cmp_meta <= cmp_in;
            r_cmp_s    <= r_cmp_meta;
        end
    end

    // Bit decision: clear the bit under test if Vin < Vdac, and raise the next
    // lower bit as the following trial. At i=0 the shifted mask is empty, so
    // no lower bit is set. Bits above i are never touched.
    always_comb begin
        w_bit_mask = c_ONE << r_idx;
        w_clr_mask = r_cmp_s ? {WIDTH{1'b0}} : w_bit_mask;
        w_decided  = (r_trial & ~w_clr_mask) | (w_bit_mask >> 1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, datapath next values and state-decoded outputs.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_idx_next    = r_idx;
        w_trial_next  = r_trial;
        w_result_load = 1'b0;
        sample        = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_SAMPLE;
                    w_cnt_next   = '0;
                    w_trial_next = c_MIDSCALE;
                end
            end
            S_SAMPLE: begin
                sample = 1'b1;
                if (r_cnt == c_SAMPLE_LAST) begin
                    w_state_next = S_SETTLE;
                    w_cnt_next   = '0;
                    w_idx_next   = c_IDX_MSB;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_next = S_DECIDE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            S_DECIDE: begin
                w_trial_next = w_decided;
                if (r_idx == '0) begin
                    w_state_next  = S_DONE;
                    w_result_load = 1'b1;
                end else begin
                    w_state_next = S_SETTLE;
                    w_idx_next   = r_idx - c_IDX_ONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (cont) begin
                    w_state_next = S_SAMPLE;
                    w_cnt_next   = '0;
                    w_trial_next = c_MIDSCALE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: phase counter, bit index, trial code and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_trial  <= c_MIDSCALE;
            r_result <= '0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_trial <= w_trial_next;
            if (w_result_load) begin
                r_result <= w_decided;
            end
        end
    end

    assign dac_code = r_trial;
    assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_adc_ctrl
//  Description : Self-checking bench for sar_adc_ctrl with an ideal and an
//                asynchronous-phase comparator model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

    localparam int c_LAT = 28;      // accepting edge to done
    localparam int c_PERIOD = 29;   // continuous mode: conversion plus DONE cycle

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       cmp_in;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] vin = 8'h00;
    logic       async_mode = 1'b0;
    logic       cmp_async = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    logic [7:0] sb[$];

    sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .cmp_in   (cmp_in),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    assign cmp_in = async_mode ? cmp_async : (vin >= dac_code);

    // Asynchronous comparator: follows each DAC change after a random delay
    // that lands inside the first SETTLE cycle.
    initial begin
        forever begin
            @(dac_code);
            #($urandom_range(1, 9));
            cmp_async = (vin >= dac_code);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                chk("result", {24'd0, result}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic set_vin(input logic [7:0] v);
        vin = v;
        cmp_async = (v >= dac_code);
    endtask

    task automatic run_conv(input logic [7:0] v, input bit chk_seq);
        int k;
        int done_k;
        int nd0;
        logic [7:0] seq[8];
        logic [7:0] code;
        logic [7:0] bitv;
        set_vin(v);
        sb.push_back(v);
        nd0 = n_done;
        code = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            bitv = 8'h01 << b;
            seq[7-b] = code | bitv;
            if (v >= seq[7-b]) code = seq[7-b];
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        done_k = -1;
        while (k < 80) begin
            if (chk_seq) begin
                if (k == 0) chk("busy_rise", {31'd0, busy}, 32'd1);
                if (k <= 3) chk("sample_high", {31'd0, sample}, 32'd1);
                if (k == 4) chk("sample_fall", {31'd0, sample}, 32'd0);
                if (k >= 4 && k <= 25 && ((k - 4) % 3) == 0)
                    chk("dac_seq", {24'd0, dac_code}, {24'd0, seq[(k-4)/3]});
            end
            if (done && done_k < 0) done_k = k;
            if (done_k >= 0 && k == done_k + 1) break;
            @(negedge clk);
            k++;
        end
        chk("done_latency", done_k, c_LAT);
        if (done_k >= 0) chk("busy_fall", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_count", n_done - nd0, 1);
    endtask

    initial begin
        int k;
        int nd0;
        int nd_seen;
        int busy_low;
        int done_k;
        int d[3];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sample", {31'd0, sample}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_dac", {24'd0, dac_code}, 32'h80);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Worked example and code extremes
        run_conv(8'hA5, 1'b1);
        run_conv(8'h00, 1'b1);
        run_conv(8'hFF, 1'b1);
        run_conv(8'h80, 1'b1);

        // Continuous mode with Vin stepping per conversion
        set_vin(8'h10);
        sb.push_back(8'h10);
        cont = 1'b1;
        nd0 = n_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        nd_seen = 0;
        busy_low = 0;
        d[0] = -1; d[1] = -1; d[2] = -1;
        while (k < 200 && nd_seen < 3) begin
            if (!busy) busy_low++;
            if (done) begin
                d[nd_seen] = k;
                nd_seen++;
                if (nd_seen == 1) begin
                    set_vin(8'h20);
                    sb.push_back(8'h20);
                end else if (nd_seen == 2) begin
                    set_vin(8'h30);
                    sb.push_back(8'h30);
                end
            end else if (nd_seen == 2 && cont) begin
                cont = 1'b0;
            end
            if (nd_seen < 3) begin
                @(negedge clk);
                k++;
            end
        end
        cont = 1'b0;
        chk("cont_first", d[0], c_LAT);
        chk("cont_space1", d[1] - d[0], c_PERIOD);
        chk("cont_space2", d[2] - d[1], c_PERIOD);
        chk("cont_busy_low", busy_low, 0);
        @(negedge clk);
        chk("cont_busy_fall", {31'd0, busy}, 32'd0);
        chk("cont_done_count", n_done - nd0, 3);
        repeat (2) @(negedge clk);

        // Starts during a conversion are ignored and not queued
        set_vin(8'h3C);
        sb.push_back(8'h3C);
        nd0 = n_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_k = -1;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            start = (j == 5 || j == 15);
            if (done && done_k < 0) done_k = j;
        end
        start = 1'b0;
        chk("ign_latency", done_k, c_LAT);
        chk("ign_done_count", n_done - nd0, 1);
        chk("ign_result", {24'd0, result}, 32'h3C);
        chk("ign_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-conversion
        set_vin(8'h5A);
        sb.push_back(8'h5A);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        sb.delete();
        nd0 = n_done;
        #2 rst = 1'b1;
        #1;
        chk("arst_sample", {31'd0, sample}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", {24'd0, result}, 32'd0);
        chk("arst_dac", {24'd0, dac_code}, 32'h80);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_no_done", n_done - nd0, 0);
        run_conv(8'h5A, 1'b1);

        // Random-phase comparator transitions during SETTLE
        async_mode = 1'b1;
        for (int j = 0; j < 100; j++) begin
            run_conv(8'($urandom_range(0, 255)), 1'b0);
        end
        async_mode = 1'b0;

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
